nes_controller_port: RTL
========================

NES_CONTROLLER_PORT -- requirements
Module: nes_controller_port

Interface
REQ-001 Parameter: TURBO_DIV, default 2, vblank pulses per turbo phase toggle (legal 1..15).
REQ-002 Port: MCLK  input  1  system clock; all logic on its rising edge.
REQ-003 Port: Reset_h  input  1  synchronous reset, active-high.
REQ-004 Port: cpu_ce  input  1  one-MCLK-cycle CPU bus strobe; bus fields qualify only when high.
REQ-005 Port: cpu_addr  input  16  CPU address.
REQ-006 Port: cpu_rd  input  1  CPU read request.
REQ-007 Port: cpu_wr  input  1  CPU write request.
REQ-008 Port: cpu_din  input  8  CPU write data.
REQ-009 Port: keycode  input  8  USB HID keycode from SOC PIO; 0x00 means no key.
REQ-010 Port: vblank  input  1  one-cycle frame-start pulse from PPU.
REQ-011 Port: cpu_dout  output  8  read data for $4016/$4017.
REQ-012 Port: cpu_dout_en  output  1  high when cpu_dout drives the CPU data bus.
REQ-013 Port: buttons  output  8  live button state, bit order A,B,Select,Start,Up,Down,Left,Right (bit0..bit7), for LEDR.

Function
REQ-014 Key map (HID code -> bit): 0x0D J->A(0), 0x0E K->B(1), 0x2C Space->Select(2), 0x28 Enter->Start(3), 0x1A W->Up(4), 0x16 S->Down(5), 0x04 A->Left(6), 0x07 D->Right(7); other codes -> 0x00.
REQ-015 buttons SHALL be registered from keycode every MCLK cycle (1-cycle latency).
REQ-016 Write ($4016, cpu_ce & cpu_wr): strobe register <= cpu_din[0]; other addresses ignored.
REQ-017 While strobe=1, shift register SHALL reload from buttons every cycle and read count SHALL hold 0.
REQ-018 Strobe 1->0 write: shift register holds last loaded value; serial sequence starts.
REQ-019 Read $4016 (cpu_ce & cpu_rd): cpu_dout = {3'b010, 4'b0000, shift[0]} combinationally in the same cycle; cpu_dout_en = 1.
REQ-020 After each $4016 read with strobe=0: shift right, shift-in 1, read count saturates at 8; reads 9+ return bit0 = 1.
REQ-021 Read with strobe=1 SHALL return current buttons[0] (A) and SHALL NOT shift.
REQ-022 Read $4017 (player 2, unconnected): cpu_dout = 0x40, cpu_dout_en = 1, no state change.
REQ-023 Non-matching address or cpu_ce=0: cpu_dout = 0x00, cpu_dout_en = 0.
REQ-024 Simultaneous write and read to $4016 in one strobe: write takes priority; no shift.
REQ-025 keycode changes during a serial sequence SHALL NOT affect shift register until next strobe.

Reset
REQ-026 On Reset_h: shift register 0x00, strobe 0, read count 0, buttons 0x00, turbo counter 0, turbo phase 0; cpu_dout 0x00, cpu_dout_en 0.
REQ-027 Reset mid-sequence SHALL abort it; first post-reset reads without strobe return bit0 = 0 for 8 reads, then 1.

Configuration
REQ-028 Macro NES_CTRL_TURBO_EN: when defined, HID 0x18 U = turbo-A, 0x0C I = turbo-B; pressed bit = turbo phase.
REQ-029 With NES_CTRL_TURBO_EN: turbo counter increments per vblank, wraps at TURBO_DIV-1 and toggles phase on wrap; vblank during reset ignored.
REQ-030 Without NES_CTRL_TURBO_EN: 0x18/0x0C map to 0x00; no turbo counter/phase logic is synthesized.

Verification
REQ-031 keycode=0x0D, write $4016=1 then 0, 10 reads -> bit0 sequence 1,0,0,0,0,0,0,0,1,1; cpu_dout=0x41/0x40.
REQ-032 keycode=0x07, strobe 1->0, 7 reads, then keycode=0x0D, 8th read -> 8th bit 1 (Right), unaffected by change.
REQ-033 strobe=1, keycode=0x0D, 3 reads -> each returns 0x41; after strobe 0, first read still 0x41.
REQ-034 Read $4017 -> 0x40, en=1; read $2002 -> 0x00, en=0; cpu_ce=0 read $4016 -> en=0, no shift.
REQ-035 Reset_h after 3 reads, then 9 reads without strobe -> 0,0,0,0,0,0,0,0,1.
REQ-036 TURBO build, TURBO_DIV=2, keycode=0x18, 4 vblank pulses, strobe+read after each -> A bits 0,1,1,0 pattern toggling every 2 frames (phase after pulses 1..4: 0,1,1,0).

Source files
------------

// File: rtl/nes_controller_port.sv
// -----------------------------------------------------------------------------
// nes_controller_port
//
// Emulates an NES standard controller behind the $4016/$4017 CPU registers,
// fed from a USB HID keycode supplied by the SOC. A keycode is mapped to one
// NES button and registered each MCLK cycle. A write to $4016 sets the strobe
// latch. While strobe is high, the shift register tracks the buttons. After
// strobe falls, each $4016 read returns the next button bit (A first) and
// shifts a 1 in behind it. $4017 (player 2) is reported as unconnected.
//
// Optional feature: define NES_CTRL_TURBO_EN to add turbo-A (HID 0x18 'U') and
// turbo-B (HID 0x0C 'I'). Each one reports a phase that toggles every
// TURBO_DIV vblank pulses. When the macro is undefined, no turbo logic exists.
//
// Parameters
//   TURBO_DIV    vblank pulses per turbo phase toggle (1..15)
//
// Ports
//   MCLK         in   system clock, rising edge
//   Reset_h      in   synchronous reset, active high
//   cpu_ce       in   one-cycle CPU bus strobe qualifying the bus fields
//   cpu_addr     in   CPU address [15:0]
//   cpu_rd       in   CPU read request
//   cpu_wr       in   CPU write request
//   cpu_din      in   CPU write data [7:0]
//   keycode      in   HID keycode, 0x00 = no key
//   vblank       in   one-cycle frame-start pulse
//   cpu_dout     out  read data for $4016/$4017
//   cpu_dout_en  out  cpu_dout is driving the CPU data bus
//   buttons      out  live buttons {Right,Left,Down,Up,Start,Select,B,A}
// -----------------------------------------------------------------------------
module nes_controller_port #(
   parameter int unsigned TURBO_DIV = 2
) (
   input  logic        MCLK,
   input  logic        Reset_h,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_din,
   input  logic [7:0]  keycode,
   input  logic        vblank,
   output logic [7:0]  cpu_dout,
   output logic        cpu_dout_en,
   output logic [7:0]  buttons
);

   localparam logic [15:0] ADDR_P1 = 16'h4016;
   localparam logic [15:0] ADDR_P2 = 16'h4017;
   localparam logic [3:0]  CNT_MAX = 4'd8;

   logic       rd_p1, wr_p1, rd_p2;
   logic [7:0] buttons_q, buttons_d;
   logic [7:0] shift_q,   shift_d;
   logic [3:0] count_q,   count_d;
   logic       strobe_q,  strobe_d;

   // Only bit 0 of a $4016 write has a function on this port.
   logic       unused_din;
   assign unused_din = ^cpu_din[7:1];

   assign rd_p1 = cpu_ce & cpu_rd & (cpu_addr == ADDR_P1);
   assign wr_p1 = cpu_ce & cpu_wr & (cpu_addr == ADDR_P1);
   assign rd_p2 = cpu_ce & cpu_rd & (cpu_addr == ADDR_P2);

`ifdef NES_CTRL_TURBO_EN
   localparam logic [3:0] TURBO_WRAP = 4'(TURBO_DIV - 1);

   logic [3:0] turbo_cnt_q,   turbo_cnt_d;
   logic       turbo_phase_q, turbo_phase_d;

   always_comb begin
      turbo_cnt_d   = turbo_cnt_q;
      turbo_phase_d = turbo_phase_q;
      if (vblank) begin
         if (turbo_cnt_q == TURBO_WRAP) begin
            turbo_cnt_d   = 4'd0;
            turbo_phase_d = ~turbo_phase_q;
         end else begin
            turbo_cnt_d = turbo_cnt_q + 4'd1;
         end
      end
   end

   // Reset has priority, so a vblank that arrives during reset is dropped.
   always_ff @(posedge MCLK) begin
      if (Reset_h) begin
         turbo_cnt_q   <= 4'd0;
         turbo_phase_q <= 1'b0;
      end else begin
         turbo_cnt_q   <= turbo_cnt_d;
         turbo_phase_q <= turbo_phase_d;
      end
   end
`else
   // The frame pulse only drives turbo timing.
   logic unused_vblank;
   assign unused_vblank = vblank;
`endif

   // Key map: one HID code lights one button bit; anything else is idle.
   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      buttons_d = 8'h00;
      case (keycode)
         8'h0D:   buttons_d = 8'h01;  // J     -> A
         8'h0E:   buttons_d = 8'h02;  // K     -> B
         8'h2C:   buttons_d = 8'h04;  // Space -> Select
         8'h28:   buttons_d = 8'h08;  // Enter -> Start
         8'h1A:   buttons_d = 8'h10;  // W     -> Up
         8'h16:   buttons_d = 8'h20;  // S     -> Down
         8'h04:   buttons_d = 8'h40;  // A     -> Left
         8'h07:   buttons_d = 8'h80;  // D     -> Right
`ifdef NES_CTRL_TURBO_EN
         8'h18:   buttons_d = {7'b0, turbo_phase_q};        // U -> turbo A
         8'h0C:   buttons_d = {6'b0, turbo_phase_q, 1'b0};  // I -> turbo B
`endif
         default: buttons_d = 8'h00;
      endcase
   end

   // Strobe latch, serial shifter and read counter.
   always_comb begin
      strobe_d = strobe_q;
      shift_d  = shift_q;
      count_d  = count_q;
      if (wr_p1) begin
         strobe_d = cpu_din[0];
      end
      if (strobe_q) begin
         // The shifter tracks the live buttons. The cycle that writes strobe
         // low still loads, so the sequence starts from the latest state.
         shift_d = buttons_q;
         count_d = 4'd0;
      end else if (rd_p1 && !wr_p1) begin
         // A write in the same bus cycle wins and suppresses the shift.
         shift_d = {1'b1, shift_q[7:1]};
         if (count_q != CNT_MAX) begin
            count_d = count_q + 4'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments, so every flop samples
   // the values from before the edge, regardless of statement order.
   always_ff @(posedge MCLK) begin
      if (Reset_h) begin
         buttons_q <= 8'h00;
         shift_q   <= 8'h00;
         count_q   <= 4'd0;
         strobe_q  <= 1'b0;
      end else begin
         buttons_q <= buttons_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         strobe_q  <= strobe_d;
      end
   end

   // Read data is combinational, in the same cycle as the strobe. The upper
   // bits mimic open-bus 0x40. While strobe is high, A is reported directly
   // from the live buttons.
   always_comb begin
      cpu_dout    = 8'h00;
      cpu_dout_en = 1'b0;
      if (!Reset_h) begin
         if (rd_p1) begin
            cpu_dout    = {3'b010, 4'b0000, (strobe_q ? buttons_q[0] : shift_q[0])};
            cpu_dout_en = 1'b1;
         end else if (rd_p2) begin
            cpu_dout    = 8'h40;
            cpu_dout_en = 1'b1;
         end
      end
   end

   assign buttons = buttons_q;

endmodule
